// File: rtl/nrd.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock,
// start/busy/done handshake, remainder correction in a final FIX cycle.
module nrd #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   a;       // signed partial remainder, one bit wider than M
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] qw;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign busy   = (state != IDLE);
    assign a_sh   = {a[WIDTH-1:0], qw[WIDTH-1]};
    assign a_step = a[WIDTH] ? (a_sh + {1'b0, m}) : (a_sh - {1'b0, m});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITER;
            ITER:    if (last)  state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            qw          <= '0;
            m           <= '0;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    m   <= divisor;
                    qw  <= dividend;
                    a   <= '0;
                    cnt <= '0;
                end
                ITER: begin
                    a   <= a_step;
                    qw  <= {qw[WIDTH-2:0], ~a_step[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    // Correction only matters modulo 2^WIDTH, so add on the low bits.
                    r           <= a[WIDTH] ? (a[WIDTH-1:0] + m) : a[WIDTH-1:0];
                    q           <= qw;
                    div_by_zero <= (m == '0);
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nrd.sv
// Self-checking bench for nrd: directed cases, handshake/reset scenarios and
// random operands compared against plain integer division.
module tb_nrd;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] q, r;

    int passed = 0;
    int total  = 0;

    nrd #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
        .divisor(divisor), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .q(q), .r(r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: unsigned integer division; divisor 0 gives all-ones / dividend.
    function automatic logic [W-1:0] ref_q(input int unsigned dd, input int unsigned dv);
        if (dv == 0) return '1;
        return W'(dd / dv);
    endfunction
    function automatic logic [W-1:0] ref_r(input int unsigned dd, input int unsigned dv);
        if (dv == 0) return W'(dd);
        return W'(dd % dv);
    endfunction

    // Assumes we are between edges; the next rising edge is the start edge.
    task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] dv);
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom;   // later changes must not matter
    endtask

    task automatic wait_done(input string tag, input int lat,
                             input logic [W-1:0] dd, input logic [W-1:0] dv);
        int k;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_q"}, q, ref_q(dd, dv));
        chk({tag, "_r"}, r, ref_r(dd, dv));
        chk({tag, "_dbz"}, div_by_zero, (dv == 0));
    endtask

    task automatic run(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv);
        @(negedge clk);
        launch(dd, dv);
        wait_done(tag, 17, dd, dv);
    endtask

    initial begin
        logic [W-1:0] qprev;
        logic         seen;
        int unsigned  a, b;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk) rst_n = 1'b1;

        run("ex", 16'h14B4, 16'h0043);
        chk("ex_q_const", q, 16'h004F);
        chk("ex_r_const", r, 16'h0007);
        @(posedge clk); #1;
        chk("done_drop", done, 0);

        run("max_by_1", 16'hFFFF, 16'h0001);
        run("max_by_max", 16'hFFFF, 16'hFFFF);
        run("small", 16'h0005, 16'h0007);
        run("zero_dd", 16'h0000, 16'h1234);
        run("dbz", 16'h1234, 16'h0000);
        chk("dbz_q_const", q, 16'hFFFF);

        // Start while busy is ignored; outputs hold during computation.
        qprev = q;
        @(negedge clk);
        launch(16'd1000, 16'd7);
        repeat (2) begin @(posedge clk); #1; end
        chk("busy_mid", busy, 1);
        start = 1'b1; dividend = 16'd50000; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_q", q, qprev);
        chk("hold_dbz", div_by_zero, 1);
        wait_done("ignore", 14, 16'd1000, 16'd7);

        // Back-to-back: start issued in the done cycle.
        launch(16'd40000, 16'd123);
        wait_done("b2b", 17, 16'd40000, 16'd123);

        // Reset mid-operation.
        @(negedge clk);
        launch(16'hBEEF, 16'h0011);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_q", q, 0);
        chk("mrst_r", r, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
        chk("mrst_no_done", seen, 0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 16'hFFFF);
            b = (i % 3 == 0) ? $urandom_range(1, 255) : $urandom_range(1, 16'hFFFF);
            run("rnd", W'(a), W'(b));
            chk("rnd_identity", (q * b) + r, a);
            chk("rnd_r_lt", (r < b), 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/nrd.md
Name: nrd

Overview:
- Sequential unsigned integer divider using the non-restoring algorithm; one quotient bit per clock.
- Takes a dividend and a divisor and returns quotient q and remainder r.
- Sits in the ALU as the divide unit, with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits (dividend, divisor, q, r)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled only while idle
dividend  input  WIDTH  unsigned dividend; captured on the start edge
divisor  input  WIDTH  unsigned divisor; captured on the start edge
busy  output  1  high while a division is in progress
done  output  1  single-cycle pulse; q/r valid from this cycle on
div_by_zero  output  1  registered with done; high when the captured divisor was 0
q  output  WIDTH  quotient, floor(dividend/divisor)
r  output  WIDTH  remainder, dividend - q*divisor

Behaviour:
- Reset:
  - rst_n low asynchronously clears busy, done, div_by_zero, q, r and all internal state to 0.
  - FSM goes to IDLE.
  - Reset mid-operation aborts the division; no done is produced.
- FSM states: IDLE, ITER, FIX.
- IDLE:
  - On a rising edge with start=1 (edge N), capture M=divisor, Q=dividend, A=0 (A is WIDTH+1 bits, signed), count=0.
  - Set busy=1 and go to ITER.
  - done is 0 in every cycle except the pulse.
- ITER, one iteration per edge (edges N+1 .. N+WIDTH):
  - If A>=0: shift {A,Q} left 1, then A = A - M.
  - Else: shift {A,Q} left 1, then A = A + M.
  - Then Q[0] = NOT A[WIDTH] (1 if the new A is non-negative).
  - M is zero-extended to WIDTH+1 bits for all add/subtract.
  - After the WIDTH-th iteration, go to FIX.
- FIX (edge N+WIDTH+1):
  - If A<0, A = A + M (remainder correction).
  - Register q=Q, r=A[WIDTH-1:0], div_by_zero=(M==0).
  - Set done=1, busy=0, return to IDLE.
- Latency:
  - done is high in the cycle after edge N+WIDTH+1, i.e. 17 cycles after the start edge for WIDTH=16.
  - done drops on the next edge.
- Output holding:
  - q, r and div_by_zero hold their values until the next FIX completes.
  - They do not change during a subsequent computation.
- Start while busy is ignored; there is no queuing.
- start in the same cycle as the done pulse (FSM in IDLE) is accepted: back-to-back operation.
- Divide by zero: no special datapath. The algorithm naturally yields q = all ones (0xFFFF) and r = dividend; div_by_zero=1 flags it.
- Operands changing after the start edge have no effect on the result.
- All arithmetic is unsigned; no overflow is possible for divisor != 0.

Test Plan:
- Directed example: start with dividend=0x14B4 (5300), divisor=0x0043 (67) -> done 17 cycles after start edge; q=0x004F (79), r=0x0007; div_by_zero=0.
- Boundaries:
  - dividend=0xFFFF, divisor=0x0001 -> q=0xFFFF, r=0.
  - dividend=0xFFFF, divisor=0xFFFF -> q=1, r=0.
  - dividend=0x0005, divisor=0x0007 -> q=0, r=5.
  - dividend=0, divisor=0x1234 -> q=0, r=0.
- Divide by zero: dividend=0x1234, divisor=0 -> q=0xFFFF, r=0x1234, div_by_zero=1 with done.
- Handshake:
  - Pulse start again while busy with different operands -> ignored; result matches the first operands only.
  - Issue start in the done cycle -> second result's done arrives exactly 17 cycles later.
- Reset mid-operation: assert rst_n=0 at iteration 8 -> busy, done, q, r go to 0 immediately; after release, no done until a new start.
- Random: 1000 random operand pairs with divisor != 0 -> q*divisor + r == dividend and r < divisor, each compared against a reference model.
